tmds_encode_mc: RTL and testbench

TMDS_ENCODE_MC -- requirements
Module: tmds_encode_mc

---
 rtl/tmds_encode_mc_if.sv | 20 ++
 rtl/tmds_encode_mc.sv | 179 +++++++++++++++++
 tb/tb_tmds_encode_mc.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_encode_mc_if.sv
// Pixel-side bus of the multi-lane TMDS encoder: period type, per-lane inputs and encoded symbols.
interface tmds_encode_mc_if #(
    parameter int unsigned CH_NUM = 3
);
    logic [1:0]           mode;
    logic [8*CH_NUM-1:0]  data_in;
    logic [2*CH_NUM-1:0]  ctrl_in;
    logic [4*CH_NUM-1:0]  terc4_in;
    logic [10*CH_NUM-1:0] data_out;

    modport master (
        output mode, data_in, ctrl_in, terc4_in,
        input  data_out
    );

    modport slave (
        input  mode, data_in, ctrl_in, terc4_in,
        output data_out
    );
endinterface

// File: rtl/tmds_encode_mc.sv
// CH_NUM-lane TMDS encoder: stage 1 ones-count, stage 2 q_m, stage 3 DC balance / output register.
// Define TMDS_TERC4_EN to compile in TERC4 data-island encoding for mode 2'b11.
module tmds_encode_mc #(
    parameter int unsigned CH_NUM = 3,
    parameter int unsigned CNT_W  = 5
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    tmds_encode_mc_if.slave bus
);
    localparam logic [1:0] MODE_VIDEO = 2'b01;
    localparam logic [1:0] MODE_GUARD = 2'b10;
`ifdef TMDS_TERC4_EN
    localparam logic [1:0] MODE_ISLAND = 2'b11;
`endif
    localparam logic signed [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic signed [CNT_W-1:0] CNT_ZERO = '0;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++) n = n + 4'(v[k]);
        return n;
    endfunction

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

`ifdef TMDS_TERC4_EN
    function automatic logic [9:0] terc4_sym(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`else
    logic unused_terc4;
    assign unused_terc4 = ^bus.terc4_in;
`endif

    // Period type travels alongside the lane data so each symbol uses its own mode.
    logic [1:0] mode_s1_q, mode_s2_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_s1_q <= '0;
            mode_s2_q <= '0;
        end else begin
            mode_s1_q <= bus.mode;
            mode_s2_q <= mode_s1_q;
        end
    end

    logic [10*CH_NUM-1:0] data_out_w;
    assign bus.data_out = data_out_w;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        localparam logic [9:0] GUARD_SYM = ((i % 3) == 1) ? 10'b0100110011 : 10'b1011001100;

        logic [7:0] d_s1_q;
        logic [3:0] n1_s1_q;
        logic [1:0] ctrl_s1_q, ctrl_s2_q;
        logic [8:0] qm_d, qm_s2_q;
        logic [3:0] qn1_d, qn1_s2_q, qn0_s2_q;
        logic       use_xnor;
        logic signed [CNT_W-1:0] cnt_q, cnt_d, diff;
        logic [9:0] out_d, out_q;
`ifdef TMDS_TERC4_EN
        logic [3:0] terc4_s1_q, terc4_s2_q;
`endif

        // Transition minimisation on the stage-1 byte.
        always_comb begin
            qm_d     = '0;
            use_xnor = (n1_s1_q > 4'd4) || ((n1_s1_q == 4'd4) && !d_s1_q[0]);
            qm_d[0]  = d_s1_q[0];
            for (int k = 1; k < 8; k++) begin
                qm_d[k] = use_xnor ? ~(qm_d[k-1] ^ d_s1_q[k]) : (qm_d[k-1] ^ d_s1_q[k]);
            end
            qm_d[8]  = ~use_xnor;
            qn1_d    = ones8(qm_d[7:0]);
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                d_s1_q    <= '0;
                n1_s1_q   <= '0;
                ctrl_s1_q <= '0;
                ctrl_s2_q <= '0;
                qm_s2_q   <= '0;
                qn1_s2_q  <= '0;
                qn0_s2_q  <= '0;
            end else begin
                d_s1_q    <= bus.data_in[8*i +: 8];
                n1_s1_q   <= ones8(bus.data_in[8*i +: 8]);
                ctrl_s1_q <= bus.ctrl_in[2*i +: 2];
                ctrl_s2_q <= ctrl_s1_q;
                qm_s2_q   <= qm_d;
                qn1_s2_q  <= qn1_d;
                qn0_s2_q  <= 4'd8 - qn1_d;
            end
        end

`ifdef TMDS_TERC4_EN
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                terc4_s1_q <= '0;
                terc4_s2_q <= '0;
            end else begin
                terc4_s1_q <= bus.terc4_in[4*i +: 4];
                terc4_s2_q <= terc4_s1_q;
            end
        end
`endif

        // DC balancing; every non-video symbol clears the disparity counter.
        always_comb begin
            out_d = ctrl_sym(ctrl_s2_q);
            cnt_d = '0;
            diff  = $signed(CNT_W'(qn1_s2_q)) - $signed(CNT_W'(qn0_s2_q));
            case (mode_s2_q)
                MODE_VIDEO: begin
                    if ((cnt_q == CNT_ZERO) || (qn1_s2_q == qn0_s2_q)) begin
                        out_d = {~qm_s2_q[8], qm_s2_q[8], qm_s2_q[8] ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
                        cnt_d = qm_s2_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                    end else if ((!cnt_q[CNT_W-1] && (qn1_s2_q > qn0_s2_q)) ||
                                 (cnt_q[CNT_W-1] && (qn0_s2_q > qn1_s2_q))) begin
                        out_d = {1'b1, qm_s2_q[8], ~qm_s2_q[7:0]};
                        cnt_d = cnt_q - diff + (qm_s2_q[8] ? CNT_TWO : CNT_ZERO);
                    end else begin
                        out_d = {1'b0, qm_s2_q[8], qm_s2_q[7:0]};
                        cnt_d = cnt_q + diff - (qm_s2_q[8] ? CNT_ZERO : CNT_TWO);
                    end
                end
                MODE_GUARD:  out_d = GUARD_SYM;
`ifdef TMDS_TERC4_EN
                MODE_ISLAND: out_d = terc4_sym(terc4_s2_q);
`endif
                default:     out_d = ctrl_sym(ctrl_s2_q);
            endcase
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                out_q <= '0;
                cnt_q <= '0;
            end else begin
                out_q <= out_d;
                cnt_q <= cnt_d;
            end
        end

        assign data_out_w[10*i +: 10] = out_q;
    end
endmodule

// File: tb/tb_tmds_encode_mc.sv
// Self-checking bench for tmds_encode_mc (4 lanes) against a per-lane behavioural TMDS model.
module tb_tmds_encode_mc;
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 5;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] G0  = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef logic [10*CH-1:0] word_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    tmds_encode_mc_if #(.CH_NUM(CH)) bus ();
    tmds_encode_mc #(.CH_NUM(CH), .CNT_W(CW)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int    n_chk  = 0;
    int    n_fail = 0;
    int    mcnt [CH];
    word_t exp_q [$];

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] r;
        case (c)
            2'b00:   r = 10'b1101010100;
            2'b01:   r = 10'b0010101011;
            2'b10:   r = 10'b0101010100;
            default: r = 10'b1010101011;
        endcase
        return r;
    endfunction

    function automatic int wrap(input int x);
        int v;
        v = x & ((1 << CW) - 1);
        if (v >= (1 << (CW - 1))) v = v - (1 << CW);
        return v;
    endfunction

    // Reference encoder for one lane, following the TMDS rules with integer arithmetic.
    task automatic model_lane(input int lane, input logic [1:0] m, input logic [7:0] d,
                              input logic [1:0] c, input logic [3:0] t, output logic [9:0] sym);
        int n1d, n1, n0;
        logic inv;
        logic [8:0] qm;
        logic [7:0] q;
        logic [3:0] unused_t;
        unused_t = t;
        sym = ctrl_code(c);
        if (m == 2'b01) begin
            n1d = 0;
            for (int k = 0; k < 8; k++) n1d += int'(d[k]);
            inv = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
            qm = '0;
            qm[0] = d[0];
            for (int k = 1; k < 8; k++) qm[k] = inv ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
            qm[8] = !inv;
            q = qm[7:0];
            n1 = 0;
            for (int k = 0; k < 8; k++) n1 += int'(q[k]);
            n0 = 8 - n1;
            if (mcnt[lane] == 0 || n1 == n0) begin
                sym = {~qm[8], qm[8], qm[8] ? q : ~q};
                mcnt[lane] += qm[8] ? (n1 - n0) : (n0 - n1);
            end else if ((mcnt[lane] > 0 && n1 > n0) || (mcnt[lane] < 0 && n0 > n1)) begin
                sym = {1'b1, qm[8], ~q};
                mcnt[lane] += 2 * int'(qm[8]) + (n0 - n1);
            end else begin
                sym = {1'b0, qm[8], q};
                mcnt[lane] += (n1 - n0) - 2 * int'(!qm[8]);
            end
            mcnt[lane] = wrap(mcnt[lane]);
        end else begin
            mcnt[lane] = 0;
            if (m == 2'b10) sym = ((lane % 3) == 1) ? G1 : G0;
`ifdef TMDS_TERC4_EN
            else if (m == 2'b11) sym = TERC4_TAB[t];
`endif
        end
    endtask

    function automatic logic [8*CH-1:0] rand_data();
        logic [8*CH-1:0] r;
        for (int l = 0; l < CH; l++) r[8*l +: 8] = 8'($urandom);
        return r;
    endfunction

    function automatic logic [4*CH-1:0] rand_nib();
        logic [4*CH-1:0] r;
        for (int l = 0; l < CH; l++) r[4*l +: 4] = 4'($urandom);
        return r;
    endfunction

    // Drive one input cycle, advance one clock, return the output and the model's value for it.
    task automatic step(input logic [1:0] m, input logic [8*CH-1:0] d, input logic [2*CH-1:0] c,
                        input logic [4*CH-1:0] t, output word_t obs, output word_t expv);
        word_t e;
        logic [9:0] s;
        bus.mode = m;
        bus.data_in = d;
        bus.ctrl_in = c;
        bus.terc4_in = t;
        for (int l = 0; l < CH; l++) begin
            model_lane(l, m, d[8*l +: 8], c[2*l +: 2], t[4*l +: 4], s);
            e[10*l +: 10] = s;
        end
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
        obs  = bus.data_out;
        expv = exp_q.pop_front();
    endtask

    // The two flushed-pipeline control symbols precede the first live output after release.
    task automatic release_reset();
        sys_rst = 1'b0;
        exp_q.delete();
        for (int l = 0; l < CH; l++) mcnt[l] = 0;
        exp_q.push_back({CH{C00}});
        exp_q.push_back({CH{C00}});
    endtask

    task automatic test_reset();
        word_t obs, expv;
        sys_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge sys_clk);
            #1;
            n_chk++;
            if (bus.data_out !== '0) begin
                n_fail++;
                $display("FAIL reset_zero cycle=%0d got=%h want=0", k, bus.data_out);
            end
        end
        release_reset();
        for (int k = 0; k < 5; k++) begin
            step(2'b01, rand_data(), '0, rand_nib(), obs, expv);
            n_chk++;
            if (k < 2 && obs !== {CH{C00}}) begin
                n_fail++;
                $display("FAIL reset_flush cycle=%0d got=%h want=%h", k, obs, {CH{C00}});
            end else if (k >= 2 && obs !== expv) begin
                n_fail++;
                $display("FAIL reset_live cycle=%0d got=%h want=%h", k, obs, expv);
            end
        end
    endtask

    task automatic test_ctrl();
        word_t obs, expv;
        logic [2*CH-1:0] ca;
        ca = '0;
        ca[1:0] = 2'b01;
        ca[3:2] = 2'b10;
        for (int s = 0; s < 3; s++) begin
            step(2'b00, rand_data(), (s == 0) ? ca : '0, rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL ctrl_model step=%0d got=%h want=%h", s, obs, expv);
            end
        end
        n_chk++;
        if (obs[9:0] !== 10'b0010101011 || obs[19:10] !== 10'b0101010100 || obs[29:20] !== C00) begin
            n_fail++;
            $display("FAIL ctrl_lanes got=%h want=%h_%h_%h", obs[29:0], C00, 10'b0101010100, 10'b0010101011);
        end
        for (int s = 0; s < 8; s++) begin
            step(2'b00, rand_data(), 8'($urandom), rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL ctrl_rand step=%0d got=%h want=%h", s, obs, expv);
            end
        end
    endtask

    task automatic test_video_zero();
        word_t obs, expv;
        logic [1:0] mt [5];
        mt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        for (int s = 0; s < 5; s++) begin
            step(mt[s], '0, '0, '0, obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL video_zero_model step=%0d got=%h want=%h", s, obs, expv);
            end
            if (s == 3) begin
                n_chk++;
                if (obs[9:0] !== 10'b0100000000) begin
                    n_fail++;
                    $display("FAIL video_zero_first got=%b want=0100000000", obs[9:0]);
                end
            end
            if (s == 4) begin
                n_chk++;
                if (obs[9:0] !== 10'b1111111111) begin
                    n_fail++;
                    $display("FAIL video_zero_second got=%b want=1111111111", obs[9:0]);
                end
            end
        end
    endtask

    task automatic test_guard();
        word_t obs, expv;
        logic [1:0] m;
        for (int s = 0; s < 9; s++) begin
            m = (s < 5 || s == 6) ? 2'b01 : ((s == 5) ? 2'b10 : 2'b00);
            step(m, (s == 6) ? '0 : rand_data(), '0, rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL guard_model step=%0d got=%h want=%h", s, obs, expv);
            end
            if (s == 7) begin
                n_chk++;
                if (obs[9:0] !== G0 || obs[19:10] !== G1 || obs[29:20] !== G0 || obs[39:30] !== G0) begin
                    n_fail++;
                    $display("FAIL guard_lanes got=%h want=%h_%h_%h_%h", obs, G0, G0, G1, G0);
                end
            end
            if (s == 8) begin
                n_chk++;
                if (obs[9:0] !== 10'b0100000000) begin
                    n_fail++;
                    $display("FAIL guard_restart got=%b want=0100000000", obs[9:0]);
                end
            end
        end
    endtask

    task automatic test_terc4();
        word_t obs, expv;
        logic [4*CH-1:0] tn;
        logic [9:0] want;
`ifdef TMDS_TERC4_EN
        want = 10'b0110011100;
`else
        want = C00;
`endif
        tn = rand_nib();
        tn[3:0] = 4'hA;
        for (int s = 0; s < 3; s++) begin
            step((s == 0) ? 2'b11 : 2'b00, rand_data(), '0, tn, obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL terc4_model step=%0d got=%h want=%h", s, obs, expv);
            end
        end
        n_chk++;
        if (obs[9:0] !== want) begin
            n_fail++;
            $display("FAIL terc4_a got=%b want=%b", obs[9:0], want);
        end
        for (int s = 0; s < 30; s++) begin
            step(2'($urandom), rand_data(), 8'($urandom), rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL terc4_mix step=%0d got=%h want=%h", s, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t obs, expv;
        logic [1:0] m;
        int worst;
        worst = 0;
        for (int s = 0; s < 300; s++) begin
            m = ($urandom_range(0, 9) < 8) ? 2'b01 : 2'($urandom_range(0, 3));
            step(m, rand_data(), 8'($urandom), rand_nib(), obs, expv);
            for (int l = 0; l < CH; l++) begin
                if (mcnt[l] > worst) worst = mcnt[l];
                if (-mcnt[l] > worst) worst = -mcnt[l];
            end
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL random_video step=%0d got=%h want=%h", s, obs, expv);
            end
        end
        n_chk++;
        if (worst > 10) begin
            n_fail++;
            $display("FAIL cnt_bound got=%0d want<=10", worst);
        end
    endtask

    task automatic test_mid_reset();
        word_t obs, expv;
        for (int s = 0; s < 6; s++) begin
            step(2'b01, rand_data(), '0, rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL midrst_pre step=%0d got=%h want=%h", s, obs, expv);
            end
        end
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        n_chk++;
        if (bus.data_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_zero got=%h want=0", bus.data_out);
        end
        release_reset();
        for (int s = 0; s < 6; s++) begin
            step(2'b01, rand_data(), '0, rand_nib(), obs, expv);
            n_chk++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL midrst_post step=%0d got=%h want=%h", s, obs, expv);
            end
        end
    endtask

    initial begin
        bus.mode     = 2'b00;
        bus.data_in  = '0;
        bus.ctrl_in  = '0;
        bus.terc4_in = '0;
        for (int l = 0; l < CH; l++) mcnt[l] = 0;
        test_reset();
        test_ctrl();
        test_video_zero();
        test_guard();
        test_terc4();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
